// File: rtl/gb_apu_pkg.sv
// Shared APU frame-sequencer types and step masks.
// Bit N of each mask marks whether step N drives that strobe.
package gb_apu_pkg;

    typedef logic [2:0] seq_step_t;

    localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
    localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
    localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

    function automatic logic step_hit(input logic [7:0] mask, input seq_step_t s);
        return mask[s];
    endfunction

endpackage

// File: rtl/gb_apu_div_tick.sv
// 512 Hz tick source: DIV bit-4 falling-edge detector, or an internal
// prescaler when GB_APU_DIV_INTERNAL_EN is defined (div_bit then unused).
module gb_apu_div_tick #(
    parameter int unsigned DIV_RATIO = 8192
) (
    input  logic clk,
    input  logic reset,
    input  logic apu_enable,
    input  logic div_bit,
    output logic tick
);

`ifdef GB_APU_DIV_INTERNAL_EN
    localparam int unsigned CW = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV_RATIO - 1);

    logic [CW-1:0] prescale;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prescale <= '0;
        end else if (!apu_enable) begin
            prescale <= '0;
        end else if (prescale == LAST) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // Fires in the cycle the counter wraps back to zero.
    assign tick = apu_enable && (prescale == LAST);
`else
    logic div_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_bit;
        end
    end

    assign tick = div_q & ~div_bit & apu_enable;
`endif

endmodule

// File: rtl/gb_apu_frame_sequencer.sv
// Game Boy APU frame sequencer: 8-step counter producing registered
// length/sweep/envelope strobes. Build option: GB_APU_DIV_INTERNAL_EN.
import gb_apu_pkg::*;

module gb_apu_frame_sequencer #(
    parameter int unsigned DIV_RATIO = 8192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       apu_enable,
    input  logic       div_bit,
    output logic       clk_length_ctr,
    output logic       clk_sweep,
    output logic       clk_envelope,
    output logic [2:0] step,
    output logic       length_skip
);

    logic      tick;
    seq_step_t step_q;
    seq_step_t step_d;
    logic      len_d;
    logic      sweep_d;
    logic      env_d;

    gb_apu_div_tick #(
        .DIV_RATIO (DIV_RATIO)
    ) u_div_tick (
        .clk        (clk),
        .reset      (reset),
        .apu_enable (apu_enable),
        .div_bit    (div_bit),
        .tick       (tick)
    );

    always_comb begin
        step_d  = step_q;
        len_d   = 1'b0;
        sweep_d = 1'b0;
        env_d   = 1'b0;
        if (!apu_enable) begin
            step_d = '0;
        end else if (tick) begin
            len_d   = step_hit(LEN_STEPS, step_q);
            sweep_d = step_hit(SWEEP_STEPS, step_q);
            env_d   = step_hit(ENV_STEPS, step_q);
            step_d  = step_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            step_q         <= '0;
            clk_length_ctr <= 1'b0;
            clk_sweep      <= 1'b0;
            clk_envelope   <= 1'b0;
        end else begin
            step_q         <= step_d;
            clk_length_ctr <= len_d;
            clk_sweep      <= sweep_d;
            clk_envelope   <= env_d;
        end
    end

    assign step        = step_q;
    assign length_skip = step_q[0];

endmodule

// File: tb/tb_gb_apu_frame_sequencer.sv
// Table-driven self-checking bench for gb_apu_frame_sequencer.
module tb_gb_apu_frame_sequencer;

    typedef struct {
        logic       rst;
        logic       en;
        logic       div;
        logic       len;
        logic       sweep;
        logic       env;
        logic [2:0] step;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       apu_enable = 1'b0;
    logic       div_bit = 1'b1;
    logic       clk_length_ctr;
    logic       clk_sweep;
    logic       clk_envelope;
    logic [2:0] step;
    logic       length_skip;

    vec_t vecs [0:127];
    int   nvec = 0;
    int   checks = 0;
    int   errors = 0;

`ifdef GB_APU_DIV_INTERNAL_EN
    localparam int unsigned RATIO = 4;
`else
    localparam int unsigned RATIO = 8192;
`endif

    gb_apu_frame_sequencer #(
        .DIV_RATIO (RATIO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .apu_enable     (apu_enable),
        .div_bit        (div_bit),
        .clk_length_ctr (clk_length_ctr),
        .clk_sweep      (clk_sweep),
        .clk_envelope   (clk_envelope),
        .step           (step),
        .length_skip    (length_skip)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic en, input logic div,
                       input logic len, input logic sw, input logic env,
                       input logic [2:0] st);
        vecs[nvec] = '{rst, en, div, len, sw, env, st};
        nvec++;
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < nvec; i++) begin
            reset      = vecs[i].rst;
            apu_enable = vecs[i].en;
            div_bit    = vecs[i].div;
            @(posedge clk);
            #1;
            check("clk_length_ctr", i, int'(clk_length_ctr), int'(vecs[i].len));
            check("clk_sweep",      i, int'(clk_sweep),      int'(vecs[i].sweep));
            check("clk_envelope",   i, int'(clk_envelope),   int'(vecs[i].env));
            check("step",           i, int'(step),           int'(vecs[i].step));
            check("length_skip",    i, int'(length_skip),    int'(vecs[i].step[0]));
        end
    endtask

    initial begin
`ifdef GB_APU_DIV_INTERNAL_EN
        // Prescaler mode: tick on every 4th enabled cycle, div_bit held still
        add(0, 1, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 16; c++) begin
            case (c)
                1, 2, 3:     add(1, 1, 1, 0, 0, 0, 0);
                4:           add(1, 1, 1, 1, 0, 0, 1);
                5, 6, 7, 8:  add(1, 1, 1, 0, 0, 0, (c == 8) ? 3'd2 : 3'd1);
                9, 10, 11:   add(1, 1, 1, 0, 0, 0, 2);
                12:          add(1, 1, 1, 1, 1, 0, 3);
                13, 14, 15:  add(1, 1, 1, 0, 0, 0, 3);
                default:     add(1, 1, 1, 0, 0, 0, 4);
            endcase
        end
        // Disable clears the prescaler and step
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 1);
        run_table();
`else
        // Reset, then a full 8-step cycle
        add(0, 1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 2);
        add(1, 1, 1, 0, 0, 0, 2);
        add(1, 1, 0, 1, 1, 0, 3);
        add(1, 1, 1, 0, 0, 0, 3);
        add(1, 1, 0, 0, 0, 0, 4);
        add(1, 1, 1, 0, 0, 0, 4);
        add(1, 1, 0, 1, 0, 0, 5);
        add(1, 1, 1, 0, 0, 0, 5);
        add(1, 1, 0, 0, 0, 0, 6);
        add(1, 1, 1, 0, 0, 0, 6);
        add(1, 1, 0, 1, 1, 0, 7);
        add(1, 1, 1, 0, 0, 0, 7);
        add(1, 1, 0, 0, 0, 1, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        // Single edge: one-cycle strobe, held low level gives no second tick
        add(1, 1, 0, 1, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0, 1);
        // Disabled: edges ignored, step forced to 0
        for (int k = 0; k < 5; k++) begin
            add(1, 0, 0, 0, 0, 0, 0);
            add(1, 0, 1, 0, 0, 0, 0);
        end
        add(1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 1);
        // Walk to step 3, drop enable on the tick cycle
        add(1, 1, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 2);
        add(1, 1, 1, 0, 0, 0, 2);
        add(1, 1, 0, 1, 1, 0, 3);
        add(1, 1, 1, 0, 0, 0, 3);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 1);
        // Walk to step 5, reset on a pending tick
        add(1, 1, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 2);
        add(1, 1, 1, 0, 0, 0, 2);
        add(1, 1, 0, 1, 1, 0, 3);
        add(1, 1, 1, 0, 0, 0, 3);
        add(1, 1, 0, 0, 0, 0, 4);
        add(1, 1, 1, 0, 0, 0, 4);
        add(1, 1, 0, 1, 0, 0, 5);
        add(1, 1, 1, 0, 0, 0, 5);
        add(0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 1);
        run_table();

        // Hand sequence: latency from falling edge to strobe, bounded wait
        begin
            int wait_cycles;
            bit seen;
            reset = 1'b0; apu_enable = 1'b1; div_bit = 1'b1;
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk); #1;
            div_bit = 1'b0;
            wait_cycles = 0;
            seen = 1'b0;
            while (!seen && wait_cycles < 10) begin
                @(posedge clk); #1;
                wait_cycles++;
                if (clk_length_ctr || clk_sweep || clk_envelope) seen = 1'b1;
            end
            check("strobe_seen", 0, int'(seen), 1);
            check("strobe_latency", 0, wait_cycles, 1);
            check("strobe_is_len", 0, int'({clk_length_ctr, clk_sweep, clk_envelope}), 4);
            @(posedge clk); #1;
            check("strobe_one_cycle", 0, int'({clk_length_ctr, clk_sweep, clk_envelope}), 0);
            check("step_after", 0, int'(step), 1);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gb_apu_frame_sequencer.md
GB_APU_FRAME_SEQUENCER -- requirements
Module: gb_apu_frame_sequencer

Interface
REQ-001 The module SHALL have parameter DIV_RATIO, default 8192, giving the clk cycles per 512 Hz tick when the internal prescaler is compiled in (4194304 / 512).
REQ-002 The module SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, synchronous and active-low; it is sampled only on the rising edge of clk.
REQ-004 The module SHALL have port apu_enable, input, 1, NR52 bit 7; low holds the sequencer idle.
REQ-005 The module SHALL have port div_bit, input, 1, DIV register bit 4 (raw level); ignored when GB_APU_DIV_INTERNAL_EN is defined.
REQ-006 The module SHALL have port clk_length_ctr, output, 1, one-cycle strobe to the length function.
REQ-007 The module SHALL have port clk_sweep, output, 1, one-cycle strobe to the channel-1 sweep unit.
REQ-008 The module SHALL have port clk_envelope, output, 1, one-cycle strobe to the envelope units.
REQ-009 The module SHALL have port step, output, 3, the index of the next step to execute.
REQ-010 The module SHALL have port length_skip, output, 1, high when the next step does not clock length (step odd); used for the extra-length-clock quirk on trigger.

Function
REQ-011 The module SHALL register div_bit into div_q every cycle; tick = div_q & ~div_bit & apu_enable (falling edge).
REQ-012 On tick the module SHALL execute step S (the current value of step), assert its strobes on the next cycle for exactly one cycle, and advance step to S+1 mod 8 (7 wraps to 0).
REQ-013 The module SHALL assert clk_length_ctr for S in {0,2,4,6}, clk_sweep for S in {2,6}, and clk_envelope for S = 7; all other strobes SHALL stay 0.
REQ-014 Latency: strobes SHALL be high in the cycle after the edge where the falling div_bit was first sampled low; outputs are registered.
REQ-015 While apu_enable is low, the module SHALL hold step at 0, keep all strobes at 0, and clear the prescaler; tick SHALL be suppressed.
REQ-016 If apu_enable falls in the same cycle as a tick, disable SHALL win: no strobe, and step becomes 0.
REQ-017 When apu_enable rises, the first subsequent tick SHALL execute step 0, asserting clk_length_ctr.
REQ-018 A div_bit rising edge or a constant level SHALL produce no tick; back-to-back falling edges require div_bit to return high in between.
REQ-019 length_skip SHALL equal step[0] combinationally from the registered step.

Reset
REQ-020 When reset = 0 at a clk edge, the module SHALL set step = 0, div_q = 0, the prescaler = 0 and all strobes = 0; length_skip therefore reads 0.
REQ-021 Reset asserted mid-sequence SHALL discard the pending strobe of that cycle; the first tick after release SHALL execute step 0.
REQ-022 Reset SHALL take priority over apu_enable and tick.

Configuration
REQ-023 With GB_APU_DIV_INTERNAL_EN defined, the module SHALL generate tick from an internal counter of width $clog2(DIV_RATIO): it counts 0..DIV_RATIO-1 while apu_enable is high, and tick fires on wrap to 0; div_bit is unused.
REQ-024 Without GB_APU_DIV_INTERNAL_EN, the prescaler SHALL not exist and tick SHALL come from the div_bit falling edge per REQ-011.

Structure
REQ-025 A shared package gb_apu_pkg SHALL hold the step-mask constants LEN_STEPS = 8'b0101_0101, SWEEP_STEPS = 8'b0100_0100, ENV_STEPS = 8'b1000_0000, together with typedef seq_step_t (logic [2:0]).
REQ-026 The edge/prescaler tick generator SHALL be one sub-module, gb_apu_div_tick; the step counter and strobe decode stay in the top module.

Verification
REQ-027 Bench: reset low 1 cycle, apu_enable=1, toggle div_bit 8 falling edges -> clk_length_ctr at steps 0,2,4,6; clk_sweep at 2,6; clk_envelope at 7; step returns to 0.
REQ-028 Bench: one div_bit falling edge at cycle N -> exactly one strobe, high only in cycle N+1; step goes 0->1 and length_skip goes 0->1.
REQ-029 Bench: apu_enable=0 with 5 div_bit falling edges -> no strobes and step=0; then raise apu_enable plus one edge -> clk_length_ctr=1 (step 0).
REQ-030 Bench: apu_enable dropped in the tick cycle at step 3 -> no strobe, step=0.
REQ-031 Bench: reset pulsed at step 5 -> step=0 and all outputs 0; the next edge produces a length strobe.
REQ-032 Bench with GB_APU_DIV_INTERNAL_EN and DIV_RATIO=4, no div_bit activity -> tick every 4 cycles; 16 cycles give steps 0-3 with length strobes at steps 0 and 2.
